// File: rtl/hazard_forward_unit.sv
// Hazard and forwarding unit for the 5-stage pipeline: decode/EX bypass selects,
// load-use and multi-cycle scoreboard stalls, and a saturating stall-cycle counter.
module hazard_forward_unit #(
  parameter int REG_ADDR_W = 5,
  parameter int MC_LATENCY = 4,
  parameter int CNT_W      = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  D_Valid_i,
  input  logic [REG_ADDR_W-1:0] D_Rs1_i,
  input  logic [REG_ADDR_W-1:0] D_Rs2_i,
  input  logic                  D_IsMC_i,
  input  logic [REG_ADDR_W-1:0] E_Rs1_i,
  input  logic [REG_ADDR_W-1:0] E_Rs2_i,
  input  logic [REG_ADDR_W-1:0] E_Rd_i,
  input  logic                  E_MemRead_i,
  input  logic [REG_ADDR_W-1:0] M_Rd_i,
  input  logic                  M_RegWrite_i,
  input  logic [REG_ADDR_W-1:0] W_Rd_i,
  input  logic                  W_RegWrite_i,
  input  logic                  MC_Start_i,
  input  logic [REG_ADDR_W-1:0] MC_Rd_i,
  input  logic                  Stall_Clr_i,
  output logic                  D_AForward_o,
  output logic                  D_BForward_o,
  output logic [1:0]            E_AForward_o,
  output logic [1:0]            E_BForward_o,
  output logic                  Stall_o,
  output logic                  Flush_E_o,
  output logic                  MC_Busy_o,
  output logic                  MC_Done_o,
  output logic [CNT_W-1:0]      Stall_Count_o
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO  = {REG_ADDR_W{1'b0}};
  localparam logic [CNT_W-1:0]      CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]      CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]      CNT_SAT   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]      CNT_RELOAD = CNT_W'(MC_LATENCY - 1);

  // A producer can bypass into a consumer only when it writes a non-zero register.
  function automatic logic fwd_hit(input logic                  we,
                                   input logic [REG_ADDR_W-1:0] rd,
                                   input logic [REG_ADDR_W-1:0] src);
    return we && (rd != REG_ZERO) && (rd == src);
  endfunction

  function automatic logic [1:0] ex_sel(input logic [REG_ADDR_W-1:0] src,
                                        input logic                  m_we,
                                        input logic [REG_ADDR_W-1:0] m_rd,
                                        input logic                  w_we,
                                        input logic [REG_ADDR_W-1:0] w_rd);
    logic [1:0] sel;
    if (fwd_hit(m_we, m_rd, src)) begin
      sel = 2'b10;
    end else if (fwd_hit(w_we, w_rd, src)) begin
      sel = 2'b01;
    end else begin
      sel = 2'b00;
    end
    return sel;
  endfunction

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [REG_ADDR_W-1:0]   pend_q, pend_d;
  logic [CNT_W-1:0]        stall_cnt_q, stall_cnt_d;
  logic                    mc_done_s;
  logic                    mc_wait_s;
  logic                    lu_s;
  logic                    raw_s;
  logic                    struct_s;
  logic                    stall_s;

  // Multi-cycle unit state, latency counter and pending destination.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      cnt_q       <= CNT_ZERO;
      pend_q      <= REG_ZERO;
      stall_cnt_q <= CNT_ZERO;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Next-state logic; a start on the final cycle reloads without passing through IDLE.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_d    = pend_q;
    mc_done_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (MC_Start_i) begin
          state_d = ST_BUSY;
          cnt_d   = CNT_RELOAD;
          pend_d  = MC_Rd_i;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (cnt_q != CNT_ZERO) begin
          cnt_d = cnt_q - CNT_ONE;
        end else begin
          mc_done_s = 1'b1;
          if (MC_Start_i) begin
            state_d = ST_BUSY;
            cnt_d   = CNT_RELOAD;
            pend_d  = MC_Rd_i;
          end else begin
            state_d = ST_IDLE;
            pend_d  = REG_ZERO;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = CNT_ZERO;
        pend_d  = REG_ZERO;
      end
    endcase
  end

  // Hazard detection; on the done cycle the result is on W, so the scoreboard releases.
  always_comb begin
    mc_wait_s = (state_q == ST_BUSY) && (cnt_q != CNT_ZERO);
    lu_s      = E_MemRead_i && (E_Rd_i != REG_ZERO) && D_Valid_i &&
                ((E_Rd_i == D_Rs1_i) || (E_Rd_i == D_Rs2_i));
    raw_s     = mc_wait_s && D_Valid_i && (pend_q != REG_ZERO) &&
                ((pend_q == D_Rs1_i) || (pend_q == D_Rs2_i));
    struct_s  = mc_wait_s && D_Valid_i && D_IsMC_i;
    stall_s   = lu_s || raw_s || struct_s;
  end

  // Stall-cycle counter: clear wins, otherwise count stalled cycles up to all-ones.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (Stall_Clr_i) begin
      stall_cnt_d = CNT_ZERO;
    end else if (stall_s && (stall_cnt_q != CNT_SAT)) begin
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // Output drive: forwarding selects are combinational, unit status follows the state register.
  always_comb begin
    D_AForward_o  = fwd_hit(W_RegWrite_i, W_Rd_i, D_Rs1_i);
    D_BForward_o  = fwd_hit(W_RegWrite_i, W_Rd_i, D_Rs2_i);
    E_AForward_o  = ex_sel(E_Rs1_i, M_RegWrite_i, M_Rd_i, W_RegWrite_i, W_Rd_i);
    E_BForward_o  = ex_sel(E_Rs2_i, M_RegWrite_i, M_Rd_i, W_RegWrite_i, W_Rd_i);
    Stall_o       = stall_s;
    Flush_E_o     = stall_s;
    MC_Busy_o     = (state_q == ST_BUSY);
    MC_Done_o     = mc_done_s;
    Stall_Count_o = stall_cnt_q;
  end

endmodule

// File: doc/hazard_forward_unit.md
Name: hazard_forward_unit

Overview:
- Combined hazard and forwarding unit for the 5-stage RISC-V pipeline.
- Generalises decode-stage write-back bypass to:
  - EX-stage forwarding from MEM and WB, with priority;
  - one-cycle load-use stall detection;
  - a sequential scoreboard for one multi-cycle execution unit (mul/div) of parametrised latency;
  - a saturating stall-cycle counter for performance monitoring.
- Sits beside the decode and execute stages; drives the forwarding muxes, the PC/IF-ID hold, and the ID/EX bubble.

Parameters:
- REG_ADDR_W, 5, register address width; register 0 is hardwired zero.
- MC_LATENCY, 4, cycles the multi-cycle unit is busy per operation; legal range 2..2**CNT_W-1.
- CNT_W, 16, width of the latency down-counter and Stall_Count.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- D_Valid  input  1  decode stage holds a valid instruction.
- D_Rs1  input  REG_ADDR_W  decode source 1.
- D_Rs2  input  REG_ADDR_W  decode source 2.
- D_IsMC  input  1  decode instruction is a multi-cycle op.
- E_Rs1  input  REG_ADDR_W  execute source 1.
- E_Rs2  input  REG_ADDR_W  execute source 2.
- E_Rd  input  REG_ADDR_W  execute destination.
- E_MemRead  input  1  execute instruction is a load.
- M_Rd  input  REG_ADDR_W  memory-stage destination.
- M_RegWrite  input  1  memory-stage write enable.
- W_Rd  input  REG_ADDR_W  write-back destination.
- W_RegWrite  input  1  write-back write enable.
- MC_Start  input  1  multi-cycle op leaves EX into the unit this cycle.
- MC_Rd  input  REG_ADDR_W  destination of that op.
- Stall_Clr  input  1  synchronous clear of Stall_Count.
- D_AForward  output  1  bypass W result into decode operand A.
- D_BForward  output  1  bypass W result into decode operand B.
- E_AForward  output  2  EX operand A select: 00 pipeline reg, 01 WB, 10 MEM.
- E_BForward  output  2  EX operand B select, same encoding.
- Stall  output  1  hold PC and IF/ID.
- Flush_E  output  1  insert bubble into ID/EX.
- MC_Busy  output  1  multi-cycle unit occupied.
- MC_Done  output  1  single-cycle pulse on the unit's final cycle.
- Stall_Count  output  CNT_W  saturating count of stalled cycles.

Behaviour:
- Reset (async, any time, including mid-operation):
  - state IDLE, latency counter 0, pending Rd 0, Stall_Count 0.
  - MC_Busy=0, MC_Done=0; an in-flight multi-cycle op is abandoned.
  - Combinational outputs track inputs with the FSM in IDLE.
- Forwarding (combinational, zero latency). A write is forwardable only if its RegWrite=1 and Rd!=0.
  - D_xForward=1 iff W forwardable and W_Rd equals the decode source.
  - E_xForward=10 if M forwardable and matches; else 01 if W forwardable and matches; else 00. MEM has priority over WB.
- Load-use: lu = E_MemRead & E_Rd!=0 & D_Valid & (E_Rd==D_Rs1 | E_Rd==D_Rs2). No state; clears naturally once the load moves to MEM (exactly one stall cycle).
- FSM states: IDLE, BUSY.
  - IDLE: MC_Start → BUSY, cnt<=MC_LATENCY-1, pend<=MC_Rd.
  - BUSY, cnt!=0: cnt<=cnt-1. MC_Start is ignored (protocol violation).
  - BUSY, cnt==0: MC_Done=1.
    - If MC_Start in the same cycle: reload cnt and pend, stay BUSY (back-to-back).
    - Otherwise go to IDLE.
  - MC_Busy=1 in BUSY, including the done cycle.
- Scoreboard stalls, only in BUSY with cnt!=0:
  - raw = D_Valid & pend!=0 & (pend==D_Rs1 | pend==D_Rs2).
  - struct = D_Valid & D_IsMC.
  - On the done cycle the result is on W_Rd/W_RegWrite, so raw is released and D_xForward supplies the value.
- Stall = Flush_E = lu | raw | struct.
- pend==0 (MC_Rd=x0): full latency is honoured, no raw stalls.
- Stall_Count:
  - Stall_Clr has priority → 0.
  - Else +1 on each cycle with Stall=1, saturating at all-ones.

Test Plan:
- Reset then M_RegWrite=1,M_Rd=5, W_RegWrite=1,W_Rd=5, E_Rs1=5 → E_AForward=10. Drop M_RegWrite → 01. M_Rd=0 with M_RegWrite=1 → 01 (x0 never forwarded).
- E_MemRead=1,E_Rd=7, D_Valid=1,D_Rs2=7 → Stall=Flush_E=1 for exactly one cycle once the load advances; Stall_Count=1.
- MC_Start with MC_Rd=9, MC_LATENCY=4, decode reads x9 → MC_Busy=1 for 4 cycles; Stall=1 for 3 cycles; MC_Done and D_BForward(W_Rd=9) in cycle 4.
- MC_Start again on the MC_Done cycle → stays BUSY a further 4 cycles with no IDLE gap. D_IsMC during cnt!=0 → structural Stall.
- rst pulsed with BUSY, cnt=2 → MC_Busy=0, Stall_Count=0 immediately, no MC_Done. Stall_Clr concurrent with Stall → Stall_Count=0.
- Force Stall for more than 2**CNT_W cycles (CNT_W=4) → Stall_Count holds at 15.
